i2c_byte_writer: RTL
====================

# i2c_byte_writer

I2C write-only master engine sitting on the responder side of the `dstream_i2c` handshake (`start`/`done`/`data`/`error`). A controller, such as the audio-codec configuration sequencer, presents a 24-bit word and pulses `start`. This block serialises the word onto the bus as a START condition, three bytes each followed by an ACK slot, and a STOP condition. It then reports completion, plus NACK status, back to the controller.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: system clock frequency.
- `I2C_HZ`, 100_000: SCL frequency.
- `N`, 24: payload width; fixed at 3 bytes. `data[23:16]` is the device address byte including R/W (must be write, bit 16 = 0), `data[15:8]` is byte 2, `data[7:0]` is byte 3.

Ports:
- `clk`  in  1  system clock. One clock domain.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request a transaction. Sampled only in IDLE.
- `data`  in  N  payload. Captured on the accepted `start` cycle.
- `done`  out  1  one-cycle pulse at the end of a transaction.
- `error`  out  1  NACK seen in the last transaction. Valid with `done`, held until the next accepted `start`.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle `done` pulses, inclusive.
- `scl`  out  1  SCL level, driven push-pull; no clock stretching.
- `sda_oe`  out  1  1 = pull SDA low, 0 = release (pad is open-drain, external pull-up).
- `sda_i`  in  1  SDA pad level, already synchronised at top level.

## Operation
- Quarter-period tick: Q = CLK_HZ/(4*I2C_HZ), integer floor, Q ≥ 2 (default 125). Counter counts 0..Q-1; a phase advances when the counter reaches Q-1.
- States: IDLE, START, BITS, STOP, DONE.
- IDLE: `scl`=1, `sda_oe`=0.
  - On `start`=1: latch `data` into the shift register, clear `error`, clear byte and bit counters, go to START.
- START, 2 quarters:
  - q0: `scl`=1, `sda_oe`=1 (SDA falls with SCL high).
  - q1: `scl`=0, `sda_oe`=1.
- BITS: 3 bytes × 9 slots (8 data bits MSB first, then ACK), 4 quarters per slot.
  - q0: `scl`=0, drive SDA (`sda_oe` = ~bit; during the ACK slot `sda_oe`=0).
  - q1 and q2: `scl`=1.
  - q3: `scl`=0.
  - SDA changes only in q0. Shift the register left at the end of q3 of each data slot.
- ACK sampling: `sda_i` is sampled on the last cycle of q1 of the ACK slot.
  - 0 = ACK: continue to the next byte, or to STOP after byte 3.
  - 1 = NACK: set `error`, skip the remaining bytes, go to STOP at the end of that slot.
- STOP, 3 quarters:
  - q0: `scl`=0, `sda_oe`=1.
  - q1: `scl`=1, `sda_oe`=1.
  - q2: `scl`=1, `sda_oe`=0 (SDA rises with SCL high).
- DONE, 1 cycle: `done`=1, then go to IDLE. A `start` present in the DONE cycle is ignored; it is accepted on the following cycle.
- A `start` while `busy` is ignored; `data` is not re-latched.

## Timing
- Reset (async assert, sync deassert at top level): `scl`=1, `sda_oe`=0, `done`=0, `error`=0, `busy`=0, state IDLE, counters 0.
- Reset asserted mid-transaction: bus released immediately with no STOP generated, and no `done` pulse.
- First START quarter begins on the cycle after `start` is accepted.
- Full transaction with no NACK: 2 + 108 + 3 = 113 quarters, i.e. 113·Q cycles. `done` pulses 113·Q cycles after the accept cycle (14125 cycles at defaults).
- NACK on byte k (k = 1..3): 2 + 36k + 3 quarters before `done`.
- `busy` rises 1 cycle after accept and falls the cycle after `done`.
- `error` changes only on an accept (cleared) or on a NACK sample (set).

## Test plan
Benches use CLK_HZ=400, I2C_HZ=10, so Q=10.
- Reset and idle: hold `rst_n`=0 then release, no `start` -> `scl`=1, `sda_oe`=0, `done`/`error`/`busy`=0 for 1000 cycles.
- Full write: `data`=0x34_1E_00, slave model ACKs all bytes -> bit sequence on SDA at SCL rise is 00110100, 00011110, 00000000 with an ACK slot after each. START and STOP edges occur with SCL high. `done` pulses at exactly 1130 cycles after accept; `error`=0.
- NACK on address: slave releases SDA on the first ACK slot -> STOP follows immediately. `done` arrives at 410 cycles; `error`=1 and holds until the next `start`.
- NACK on byte 2 -> `done` at 770 cycles, `error`=1. A subsequent ACKed transaction clears `error` on accept and completes with `error`=0.
- Start while busy, and start during the DONE cycle: `start`=1 with `data`=0xFF_FF_FF at cycle 500 -> ignored, the original payload is sent. `start` asserted in the DONE cycle is accepted one cycle later.
- Reset mid-byte: assert `rst_n`=0 at cycle 300 -> same cycle `scl`=1, `sda_oe`=0, `busy`=0, and no `done` pulse follows.

Source files
------------

// File: rtl/i2c_byte_writer.sv
// I2C write master: START, 3 bytes + ACK slots, STOP; done pulses 113*Q cycles after accept (fewer on NACK).
// No backpressure: start is taken only in IDLE, ignored while busy or in the DONE cycle.
module i2c_byte_writer #(
    parameter int CLK_HZ = 50_000_000,
    parameter int I2C_HZ = 100_000,
    parameter int N      = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] data,
    output logic         done,
    output logic         error,
    output logic         busy,
    output logic         scl,
    output logic         sda_oe,
    input  logic         sda_i
);

    localparam int Q  = CLK_HZ / (4 * I2C_HZ);
    localparam int CW = (Q > 1) ? $clog2(Q) : 1;
    localparam logic [CW-1:0] Q_LAST = CW'(Q - 1);
    localparam logic [CW-1:0] Q_PEN  = CW'(Q - 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_BITS, S_STOP, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     qtr_q, qtr_d;
    logic [3:0]     slot_q, slot_d;
    logic [1:0]     byte_q, byte_d;
    logic [N-1:0]   shift_q, shift_d;
    logic           error_q, error_d;
    logic           tick;

    assign tick  = (cnt_q == Q_LAST);
    assign busy  = (state_q != S_IDLE);
    assign error = error_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        qtr_d   = qtr_q;
        slot_d  = slot_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        error_d = error_q;
        scl     = 1'b1;
        sda_oe  = 1'b0;
        done    = 1'b0;

        if (state_q == S_START || state_q == S_BITS || state_q == S_STOP) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_START;
                    shift_d = data;
                    error_d = 1'b0;
                    byte_d  = '0;
                    slot_d  = '0;
                    qtr_d   = '0;
                end
            end
            S_START: begin
                scl    = (qtr_q == 2'd0);
                sda_oe = 1'b1;
                if (tick) begin
                    if (qtr_q == 2'd1) begin
                        state_d = S_BITS;
                        qtr_d   = '0;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            S_BITS: begin
                scl    = (qtr_q == 2'd1) || (qtr_q == 2'd2);
                sda_oe = (slot_q == 4'd8) ? 1'b0 : ~shift_q[N-1];
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (slot_q == 4'd8 && qtr_q == 2'd1 && sda_i) begin
                        error_d = 1'b1;
                    end
                    if (qtr_q == 2'd3) begin
                        if (slot_q != 4'd8) begin
                            shift_d = shift_q << 1;
                            slot_d  = slot_q + 4'd1;
                        end else begin
                            // error_q was set in q1 of this slot if the slave NACKed
                            slot_d = '0;
                            if (error_q || byte_q == 2'd2) begin
                                state_d = S_STOP;
                            end else begin
                                byte_d = byte_q + 2'd1;
                            end
                        end
                    end
                end
            end
            S_STOP: begin
                scl    = (qtr_q != 2'd0);
                sda_oe = (qtr_q != 2'd2);
                // last STOP quarter is one cycle short; the DONE cycle completes it with the same bus levels
                if (qtr_q == 2'd2) begin
                    if (cnt_q == Q_PEN) begin
                        state_d = S_DONE;
                    end
                end else if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            qtr_q   <= '0;
            slot_q  <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qtr_q   <= qtr_d;
            slot_q  <= slot_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            error_q <= error_d;
        end
    end

endmodule
